// File: rtl/dmem_port_if.sv
// Request/response bus between the core memory stage and dmem_port.
// Master drives requests and rsp_ready; slave returns req_ready and the response.
interface dmem_port_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    modport master (
        output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface

// File: rtl/dmem_port.sv
// Byte-addressable data RAM with RISC-V load/store lane steering and a registered video read port.
// Latency: response READ_LAT cycles after accept; vdata one cycle after vaddr.
// Backpressure: one request in flight; rsp_ready low holds the response and keeps req_ready low.
module dmem_port #(
    parameter int DEPTH_WORDS = 512,
    parameter int VADDR_W     = 9,
    parameter int READ_LAT    = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    dmem_port_if.slave         bus,
    input  logic [VADDR_W-1:0] vaddr,
    output logic [31:0]        vdata
);
    localparam int IDX_W = $clog2(DEPTH_WORDS);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t            state;
    logic [2:0]        cnt;
    logic [31:0]       mem [DEPTH_WORDS];

    logic              accept;
    logic              in_range;
    logic              err;
    logic [IDX_W-1:0]  idx;
    logic [3:0]        byte_en;
    logic [31:0]       wdata_rep;
    logic [31:0]       rword;
    logic [7:0]        lane_b;
    logic [15:0]       lane_h;
    logic [31:0]       load_data;
    logic [31:0]       vidx;
    logic              unused_vaddr_lsb;

    assign accept   = bus.req_valid & bus.req_ready;
    assign in_range = {2'b00, bus.req_addr[31:2]} < 32'(DEPTH_WORDS);
    assign idx      = bus.req_addr[IDX_W+1:2];

    always_comb begin
        err = !in_range;
        case (bus.req_size)
            2'b01:   if (bus.req_addr[0]) err = 1'b1;
            2'b10:   if (bus.req_addr[1:0] != 2'b00) err = 1'b1;
            2'b11:   err = 1'b1;
            default: ;
        endcase
    end

    always_comb begin
        byte_en   = 4'b0000;
        wdata_rep = bus.req_wdata;
        case (bus.req_size)
            2'b00: begin
                byte_en   = 4'b0001 << bus.req_addr[1:0];
                wdata_rep = {4{bus.req_wdata[7:0]}};
            end
            2'b01: begin
                byte_en   = bus.req_addr[1] ? 4'b1100 : 4'b0011;
                wdata_rep = {2{bus.req_wdata[15:0]}};
            end
            2'b10:   byte_en = 4'b1111;
            default: ;
        endcase
    end

    // Read is combinational off the RAM so the response sees pre-store contents.
    assign rword  = mem[idx];
    assign lane_b = rword[{bus.req_addr[1:0], 3'b000} +: 8];
    assign lane_h = bus.req_addr[1] ? rword[31:16] : rword[15:0];

    always_comb begin
        case (bus.req_size)
            2'b00:   load_data = bus.req_unsigned ? {24'h0, lane_b} : {{24{lane_b[7]}}, lane_b};
            2'b01:   load_data = bus.req_unsigned ? {16'h0, lane_h} : {{16{lane_h[15]}}, lane_h};
            default: load_data = rword;
        endcase
    end

    always_ff @(posedge clk) begin
        if (accept && bus.req_we && !err) begin
            for (int i = 0; i < 4; i++) begin
                if (byte_en[i]) mem[idx][8*i +: 8] <= wdata_rep[8*i +: 8];
            end
        end
    end

    assign vidx             = 32'(vaddr[VADDR_W-1:2]);
    assign unused_vaddr_lsb = ^vaddr[1:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) vdata <= '0;
        else        vdata <= (vidx < 32'(DEPTH_WORDS)) ? mem[vidx[IDX_W-1:0]] : 32'h0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            cnt           <= '0;
            bus.req_ready <= 1'b0;
            bus.rsp_valid <= 1'b0;
            bus.rsp_rdata <= '0;
            bus.rsp_err   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    bus.req_ready <= 1'b1;
                    if (accept) begin
                        bus.req_ready <= 1'b0;
                        bus.rsp_err   <= err;
                        bus.rsp_rdata <= (err || bus.req_we) ? 32'h0 : load_data;
                        if (READ_LAT == 1) begin
                            state         <= RESP;
                            bus.rsp_valid <= 1'b1;
                        end else begin
                            state <= WAIT;
                            cnt   <= 3'(READ_LAT - 1);
                        end
                    end
                end
                WAIT: begin
                    if (cnt == 3'd1) begin
                        state         <= RESP;
                        cnt           <= '0;
                        bus.rsp_valid <= 1'b1;
                    end else begin
                        cnt <= cnt - 3'd1;
                    end
                end
                RESP: begin
                    if (bus.rsp_ready) begin
                        state         <= IDLE;
                        bus.rsp_valid <= 1'b0;
                        bus.req_ready <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_dmem_port.sv
// Drives two dmem_port instances (READ_LAT 1 and 4) with identical traffic and
// checks both against a byte-array memory model.
module tb_dmem_port;
    localparam int DEPTH = 512;
    localparam int VW    = 12;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            req_valid, req_we, req_unsigned;
    logic [1:0]      req_size;
    logic [31:0]     req_addr, req_wdata;
    logic [VW-1:0]   vaddr;
    logic [1:0]      rr, rdy, rv, re;
    logic [31:0]     rd [2];
    logic [31:0]     vd [2];

    logic [7:0]      mb [DEPTH*4];
    int              n_chk = 0;
    int              n_err = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 2; g++) begin : gen_dut
        dmem_port_if bus ();
        assign bus.req_valid    = req_valid;
        assign bus.req_we       = req_we;
        assign bus.req_size     = req_size;
        assign bus.req_unsigned = req_unsigned;
        assign bus.req_addr     = req_addr;
        assign bus.req_wdata    = req_wdata;
        assign bus.rsp_ready    = rr[g];
        assign rdy[g]           = bus.req_ready;
        assign rv[g]            = bus.rsp_valid;
        assign re[g]            = bus.rsp_err;
        assign rd[g]            = bus.rsp_rdata;

        dmem_port #(.DEPTH_WORDS(DEPTH), .VADDR_W(VW), .READ_LAT(g == 0 ? 1 : 4)) u_dut (
            .clk   (clk),
            .rst_n (rst_n),
            .bus   (bus),
            .vaddr (vaddr),
            .vdata (vd[g])
        );
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    function automatic int lat(int k);
        return (k == 0) ? 1 : 4;
    endfunction

    function automatic int nbytes(logic [1:0] sz);
        return (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
    endfunction

    function automatic bit m_err(logic [1:0] sz, logic [31:0] a);
        if ((a >> 2) >= 32'(DEPTH)) return 1'b1;
        if (sz == 2'd3) return 1'b1;
        return (a % nbytes(sz)) != 0;
    endfunction

    function automatic logic [31:0] m_load(logic [1:0] sz, logic uns, logic [31:0] a);
        int ai = int'(a);
        int nb = nbytes(sz);
        int v  = 0;
        for (int i = nb - 1; i >= 0; i--) v = (v << 8) | int'(mb[ai+i]);
        if (!uns && nb < 4 && v >= (1 << (8*nb - 1))) v = v - (1 << (8*nb));
        return 32'(v);
    endfunction

    function automatic void m_store(logic [1:0] sz, logic [31:0] a, logic [31:0] wd);
        int ai = int'(a);
        for (int i = 0; i < nbytes(sz); i++) mb[ai+i] = wd[8*i +: 8];
    endfunction

    function automatic logic [31:0] m_vword(logic [VW-1:0] va);
        int w = int'(va >> 2);
        if (w >= DEPTH) return 32'h0;
        return {mb[4*w+3], mb[4*w+2], mb[4*w+1], mb[4*w]};
    endfunction

    function automatic logic [31:0] rnd_word();
        int r = $urandom_range(0, 19);
        return (r < 16) ? 32'(r) : 32'(DEPTH - 20 + r);
    endfunction

    // One transaction on both DUTs; entered and left on a negedge with both idle.
    task automatic do_req(input logic we, input logic [1:0] sz, input logic uns,
                          input logic [31:0] a, input logic [31:0] wd,
                          input int hold, input logic [VW-1:0] va);
        bit          e;
        logic [31:0] exp_rd, v_pre, v_post;
        bit          seen [2] = '{0, 0};
        bit          done [2] = '{0, 0};
        int          held [2] = '{0, 0};
        e      = m_err(sz, a);
        exp_rd = (e || we) ? 32'h0 : m_load(sz, uns, a);
        v_pre  = m_vword(va);
        if (we && !e) m_store(sz, a, wd);
        v_post = m_vword(va);

        check("entry_req_ready", 32'(rdy), 32'd3);
        req_valid = 1'b1; req_we = we; req_size = sz; req_unsigned = uns;
        req_addr = a; req_wdata = wd; vaddr = va;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        for (int n = 1; n <= 40 && !(done[0] && done[1]); n++) begin
            if (n > 1) @(negedge clk);
            for (int k = 0; k < 2; k++) begin
                if (n == 1) check($sformatf("vdata_old%0d", k), vd[k], v_pre);
                if (n == 2) check($sformatf("vdata_new%0d", k), vd[k], v_post);
                if (!done[k]) begin
                    if (rr[k]) begin
                        check($sformatf("post_hs_valid%0d", k), 32'(rv[k]), 32'd0);
                        check($sformatf("post_hs_ready%0d", k), 32'(rdy[k]), 32'd1);
                        rr[k] = 1'b0;
                        done[k] = 1'b1;
                    end else if (rv[k]) begin
                        if (!seen[k]) begin
                            seen[k] = 1'b1;
                            check($sformatf("latency%0d", k), 32'(n), 32'(lat(k)));
                        end else begin
                            check($sformatf("held_ready%0d", k), 32'(rdy[k]), 32'd0);
                        end
                        check($sformatf("rdata%0d a=%h", k, a), rd[k], exp_rd);
                        check($sformatf("err%0d a=%h", k, a), 32'(re[k]), 32'(e));
                        if (held[k] >= hold) rr[k] = 1'b1;
                        else held[k]++;
                    end
                end
            end
        end
        if (!(done[0] && done[1])) begin
            check("response_timeout", 32'({done[1], done[0]}), 32'd3);
            rr = 2'b00;
        end
    endtask

    task automatic reset_check(input logic [VW-1:0] va);
        @(negedge clk);
        rst_n = 1'b0; rr = 2'b00;
        req_valid = 1'b1; req_we = 1'b1; req_size = 2'd2; req_unsigned = 1'b0;
        req_addr = 32'h20; req_wdata = 32'h1234_5678; vaddr = va;
        repeat (3) @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            check($sformatf("rst_req_ready%0d", k), 32'(rdy[k]), 32'd0);
            check($sformatf("rst_rsp_valid%0d", k), 32'(rv[k]), 32'd0);
            check($sformatf("rst_rdata%0d", k), rd[k], 32'h0);
            check($sformatf("rst_err%0d", k), 32'(re[k]), 32'd0);
            check($sformatf("rst_vdata%0d", k), vd[k], 32'h0);
        end
        rst_n = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        check("release_req_ready", 32'(rdy), 32'd3);
        check("release_rsp_valid", 32'(rv), 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [31:0] a, w;
        logic [VW-1:0] va;
        rst_n = 1'b1;
        req_valid = 1'b0; req_we = 1'b0; req_size = 2'd0; req_unsigned = 1'b0;
        req_addr = '0; req_wdata = '0; vaddr = '1; rr = 2'b00;

        reset_check('1);

        // Initialise every word the random traffic can touch.
        for (int i = 0; i < 20; i++) begin
            w = (i < 16) ? 32'(i) : 32'(DEPTH - 20 + i);
            do_req(1'b1, 2'd2, 1'b0, w * 4, $urandom, 0, '1);
        end

        // Store attempted while held in reset must not land.
        reset_check(12'h020);
        do_req(1'b0, 2'd2, 1'b0, 32'h20, 32'h0, 0, 12'h020);

        do_req(1'b1, 2'd2, 1'b0, 32'h10, 32'hDEAD_BEEF, 0, 12'h010);
        do_req(1'b0, 2'd0, 1'b0, 32'h13, 32'h0, 0, 12'h010);
        do_req(1'b0, 2'd0, 1'b1, 32'h13, 32'h0, 0, 12'h010);
        do_req(1'b0, 2'd1, 1'b0, 32'h12, 32'h0, 0, 12'h010);
        do_req(1'b0, 2'd1, 1'b1, 32'h12, 32'h0, 0, 12'h010);
        do_req(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 0, 12'h010);
        do_req(1'b1, 2'd0, 1'b0, 32'h11, 32'hFFFF_FF55, 0, 12'h010);
        do_req(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 0, 12'h010);
        do_req(1'b1, 2'd1, 1'b0, 32'h12, 32'hABCD_1234, 0, 12'h010);
        do_req(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 0, 12'h010);

        // Error cases, then read back to confirm nothing moved.
        do_req(1'b0, 2'd2, 1'b0, 32'h02, 32'h0, 0, 12'h000);
        do_req(1'b1, 2'd1, 1'b0, 32'h01, 32'hFFFF_FFFF, 0, 12'h000);
        do_req(1'b1, 2'd3, 1'b0, 32'h10, 32'hFFFF_FFFF, 0, 12'h010);
        do_req(1'b1, 2'd2, 1'b0, 32'(DEPTH * 4), 32'hFFFF_FFFF, 0, 12'h800);
        do_req(1'b0, 2'd2, 1'b0, 32'h00, 32'h0, 0, 12'h000);
        do_req(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 0, 12'h010);

        do_req(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 5, 12'h010);
        do_req(1'b1, 2'd2, 1'b0, 32'h10, 32'hCAFE_F00D, 0, 12'h010);

        // Reset while both responses are pending: committed store survives.
        w = $urandom;
        m_store(2'd2, 32'h24, w);
        req_valid = 1'b1; req_we = 1'b1; req_size = 2'd2; req_addr = 32'h24; req_wdata = w;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        check("midrst_rsp_valid", 32'(rv), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("midrst_req_ready", 32'(rdy), 32'd3);
        do_req(1'b0, 2'd2, 1'b0, 32'h24, 32'h0, 0, 12'h024);

        for (int t = 0; t < 200; t++) begin
            if ($urandom_range(0, 9) == 0)
                a = ($urandom_range(0, 1) == 0) ? 32'(DEPTH * 4) + $urandom_range(0, 4095)
                                                 : ($urandom | 32'h8000_0000);
            else
                a = rnd_word() * 4 + $urandom_range(0, 3);
            if ($urandom_range(0, 7) == 0)
                va = VW'(($urandom_range(DEPTH, 1023) << 2) + $urandom_range(0, 3));
            else
                va = VW'(rnd_word() * 4 + $urandom_range(0, 3));
            do_req(1'($urandom), 2'($urandom), 1'($urandom), a, $urandom,
                   $urandom_range(0, 3), va);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule

// File: doc/dmem_port.md
# dmem_port

Parametrised data-memory block for the single-cycle core's successor datapath: a byte-addressable, word-organised RAM behind a valid/ready request–response port, plus an independent registered read port for the video scanner. The block does all RISC-V load/store lane steering internally (SB/SH/SW stores, LB/LH/LW/LBU/LHU loads with sign/zero extension) and flags misaligned or out-of-range accesses instead of corrupting memory. It sits between the core's memory stage and the video controller.

## Interface
- DEPTH_WORDS, 512, number of 32-bit words; power of two, ≥ 4
- VADDR_W, 9, video port byte-address width
- READ_LAT, 1, cycles from request accept to rsp_valid; 1..4
- clk  in  1  clock; all state updates on rising edge
- rst_n  in  1  asynchronous, active-low reset
- req_valid  in  1  request present
- req_ready  out  1  block can accept a request
- req_we  in  1  1 = store, 0 = load
- req_size  in  2  00 byte, 01 half, 10 word, 11 reserved
- req_unsigned  in  1  load zero-extends (LBU/LHU); ignored for word/store
- req_addr  in  32  byte address
- req_wdata  in  32  store data, right-aligned (byte in [7:0], half in [15:0])
- rsp_valid  out  1  response present
- rsp_ready  in  1  consumer accepts response
- rsp_rdata  out  32  load data, aligned and extended; 0 for stores and errors
- rsp_err  out  1  misaligned, reserved size, or out-of-range
- vaddr  in  VADDR_W  video byte address; word index = vaddr[VADDR_W-1:2]
- vdata  out  32  registered word at vaddr

## Operation
- FSM: IDLE, WAIT, RESP. req_ready = 1 only in IDLE.
- IDLE: on req_valid & req_ready → accept. If READ_LAT = 1 go to RESP, else WAIT with counter = READ_LAT-1.
- WAIT: decrement counter each cycle; at 1 → RESP.
- RESP: rsp_valid = 1; rsp_rdata/rsp_err stable until rsp_valid & rsp_ready, then → IDLE.
- Error check at accept: size 11; half with addr[0]=1; word with addr[1:0]≠0; word index addr[31:2] ≥ DEPTH_WORDS. Error → no write, rsp_err=1, rsp_rdata=0.
- Store lanes: byte → wdata[7:0] replicated, byte_en = 1<<addr[1:0]; half → wdata[15:0] replicated, byte_en = 0011 or 1100 by addr[1]; word → 1111. Only enabled bytes change.
- Load: word read at accept edge (pre-write contents), lane selected by addr[1:0]; byte/half sign-extended unless req_unsigned.
- Video port: vdata ← RAM[vaddr word index] every cycle, independent of FSM; out-of-range index (VADDR_W > log2(DEPTH_WORDS)+2) returns 0.
- RAM contents are not reset; reset only affects FSM and output registers.

## Timing
- Reset (rst_n low, async): state IDLE, req_ready 0 while rst_n low then 1 from first cycle after release, rsp_valid 0, rsp_rdata 0, rsp_err 0, vdata 0, counter 0.
- Accept at edge T: store commits at edge T; load data captured at edge T; rsp_valid high in cycle following edge T+READ_LAT-1 (i.e. READ_LAT cycles after accept).
- Peak throughput: one request per READ_LAT+1 cycles with rsp_ready held high.
- Backpressure: rsp_ready low holds RESP indefinitely; no new request accepted.
- Video read of a word being stored at the same edge returns old contents; next cycle returns new.
- rst_n asserted mid-transaction: pending response dropped, any store already committed at its accept edge remains.

## Test plan
- Reset: hold rst_n low 3 cycles with req_valid=1 → req_ready=0, rsp_valid=0, vdata=0, no RAM write; release → req_ready=1 next cycle.
- SW 0xDEADBEEF @0x10, then LB/LBU @0x13, LH/LHU @0x12, LW @0x10 → 0xFFFFFFDE, 0x000000DE, 0xFFFFDEAD, 0x0000DEAD, 0xDEADBEEF, each rsp_valid exactly READ_LAT cycles after accept.
- SB 0x55 @0x11 over 0xDEADBEEF → LW @0x10 = 0xDEAD55EF; SH 0x1234 @0x12 → 0x123455EF.
- LW @0x02, SH @0x01, size 11, SW @(DEPTH_WORDS*4) → rsp_err=1, rsp_rdata=0, memory unchanged.
- Hold rsp_ready=0 for 5 cycles → rsp_valid/rsp_rdata stable, req_ready=0; raise → IDLE next cycle; repeat for READ_LAT = 1 and 4.
- vaddr=0x10 while SW 0xCAFEF00D @0x10 accepted at edge T → vdata old value after T, 0xCAFEF00D after T+1.
